// File: rtl/multicycle_ctrl.sv
// Multicycle LEGv8 control FSM: sequences fetch/decode/execute/memory/writeback
// from IR opcode with a variable-latency memory handshake, plus retire/stall counters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// FETCH   | read instruction at PC, compute PC+4, wait for mem_ready
// DECODE  | compute branch target into ALUOut, dispatch on opcode
// MEMADDR | compute load/store effective address
// MEMRD   | data read at ALUOut, wait for mem_ready
// WBMEM   | write loaded data to register file
// MEMWR   | data write at ALUOut, wait for mem_ready
// EXEC    | R-type ALU operation
// WBALU   | write ALUOut to register file
// BRANCH  | CBZ compare, load target PC if zero
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      Op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             IorD,
  output logic             IRWrite,
  output logic             Reg2Loc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired_count,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADDR, S_MEMRD, S_WBMEM,
    S_MEMWR, S_EXEC, S_WBALU, S_BRANCH
  } state_t;

  localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
  localparam logic [10:0] OP_STUR = 11'b111_1100_0000;
  localparam logic [10:0] OP_ADD  = 11'b100_0101_1000;
  localparam logic [10:0] OP_SUB  = 11'b110_0101_1000;
  localparam logic [10:0] OP_AND  = 11'b100_0101_0000;
  localparam logic [10:0] OP_ORR  = 11'b101_0101_0000;

  state_t state, state_nxt;
  logic   is_ldur, is_stur, is_cbz, is_rtype;
  logic   retire, stall;

  assign is_ldur  = (Op == OP_LDUR);
  assign is_stur  = (Op == OP_STUR);
  assign is_cbz   = (Op[10:3] == 8'b1011_0100);
  assign is_rtype = (Op == OP_ADD) || (Op == OP_SUB) || (Op == OP_AND) || (Op == OP_ORR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    PCWrite    = 1'b0;
    PCSrc      = 1'b0;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    Reg2Loc    = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    illegal_op = 1'b0;
    retire     = 1'b0;
    stall      = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        if (mem_ready) begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          state_nxt = S_DECODE;
        end else begin
          stall = 1'b1;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        Reg2Loc = is_stur || is_cbz;
        if (is_ldur || is_stur) state_nxt = S_MEMADDR;
        else if (is_rtype)      state_nxt = S_EXEC;
        else if (is_cbz)        state_nxt = S_BRANCH;
        else begin
          illegal_op = 1'b1;
          state_nxt  = S_FETCH;
        end
      end
      S_MEMADDR: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        state_nxt = is_ldur ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (mem_ready) state_nxt = S_WBMEM;
        else           stall     = 1'b1;
      end
      S_WBMEM: begin
        RegWrite  = 1'b1;
        MemtoReg  = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        Reg2Loc  = 1'b1;
        if (mem_ready) begin
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end else begin
          stall = 1'b1;
        end
      end
      S_EXEC: begin
        ALUSrcA   = 1'b1;
        ALUOp     = 2'b10;
        state_nxt = S_WBALU;
      end
      S_WBALU: begin
        RegWrite  = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        Reg2Loc   = 1'b1;
        ALUOp     = 2'b01;
        PCSrc     = 1'b1;
        PCWrite   = zero;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
    // Reset forces FETCH, whose Moore outputs are not quiet, so gate everything here.
    if (!reset) begin
      PCWrite    = 1'b0;
      PCSrc      = 1'b0;
      IorD       = 1'b0;
      IRWrite    = 1'b0;
      Reg2Loc    = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ALUOp      = 2'b00;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      illegal_op = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_count <= '0;
      stall_count   <= '0;
    end else begin
      if (retire) retired_count <= retired_count + CNT_W'(1);
      if (stall)  stall_count   <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction cycle schedules built from the
// instruction-level rules drive the DUT and give the expected outputs each cycle.
module tb_multicycle_ctrl;
  localparam int CW = 4;

  localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
  localparam logic [10:0] OP_STUR = 11'b111_1100_0000;
  localparam logic [10:0] OP_ADD  = 11'b100_0101_1000;
  localparam logic [10:0] OP_CBZ  = 11'b101_1010_0000;
  localparam int K_LD = 0, K_ST = 1, K_R = 2, K_CBZ = 3, K_ILL = 4;

  typedef struct packed {
    logic       pc_write, pc_src, iord, ir_write, reg2loc, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       mem_read, mem_write, mem_to_reg, reg_write, illegal;
  } outs_t;

  typedef struct {
    logic [10:0] op;
    logic        zero;
    logic        ready;
    outs_t       exp;
    int          ret_inc;
    int          stall_inc;
  } cyc_t;

  logic clk = 1'b0, reset = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic [10:0] Op = '0;
  logic PCWrite, PCSrc, IorD, IRWrite, Reg2Loc, ALUSrcA, MemRead, MemWrite;
  logic MemtoReg, RegWrite, illegal_op;
  logic [1:0] ALUSrcB, ALUOp;
  logic [CW-1:0] retired_count, stall_count;

  int n_pass = 0, n_total = 0;
  int exp_ret = 0, exp_stall = 0;
  cyc_t sched[$];
  logic [10:0] r_ops [4] = '{11'b100_0101_1000, 11'b110_0101_1000,
                             11'b100_0101_0000, 11'b101_0101_0000};

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .Op(Op), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .IorD(IorD), .IRWrite(IRWrite),
    .Reg2Loc(Reg2Loc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .illegal_op(illegal_op),
    .retired_count(retired_count), .stall_count(stall_count)
  );

  function automatic outs_t dut_o();
    return {PCWrite, PCSrc, IorD, IRWrite, Reg2Loc, ALUSrcA, ALUSrcB, ALUOp,
            MemRead, MemWrite, MemtoReg, RegWrite, illegal_op};
  endfunction

  function automatic int classify(logic [10:0] op);
    if (op == OP_LDUR) return K_LD;
    if (op == OP_STUR) return K_ST;
    if (op[10:3] == 8'b1011_0100) return K_CBZ;
    foreach (r_ops[i]) if (op == r_ops[i]) return K_R;
    return K_ILL;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic push(logic [10:0] op, logic z, logic r, outs_t e, int ri, int si);
    cyc_t c;
    c.op = op; c.zero = z; c.ready = r; c.exp = e;
    c.ret_inc = ri; c.stall_inc = si;
    sched.push_back(c);
  endtask

  // Expand one instruction into its cycle-by-cycle expectations.
  task automatic add_instr(logic [10:0] op, int sf, int sm, logic z);
    outs_t o;
    int k = classify(op);
    for (int i = 0; i <= sf; i++) begin
      o = '0; o.mem_read = 1; o.alu_src_b = 2'b01;
      if (i == sf) begin o.ir_write = 1; o.pc_write = 1; end
      push(11'($urandom), 1'($urandom), i == sf, o, 0, (i == sf) ? 0 : 1);
    end
    o = '0; o.alu_src_b = 2'b11;
    o.reg2loc = (k == K_ST || k == K_CBZ);
    o.illegal = (k == K_ILL);
    push(op, 1'($urandom), 1'($urandom), o, 0, 0);
    if (k == K_LD || k == K_ST) begin
      o = '0; o.alu_src_a = 1; o.alu_src_b = 2'b10;
      push(op, 1'($urandom), 1'($urandom), o, 0, 0);
      for (int i = 0; i <= sm; i++) begin
        o = '0; o.iord = 1;
        if (k == K_LD) o.mem_read = 1;
        else begin o.mem_write = 1; o.reg2loc = 1; end
        push(op, 1'($urandom), i == sm, o, (k == K_ST && i == sm) ? 1 : 0,
             (i == sm) ? 0 : 1);
      end
      if (k == K_LD) begin
        o = '0; o.reg_write = 1; o.mem_to_reg = 1;
        push(op, 1'($urandom), 1'($urandom), o, 1, 0);
      end
    end else if (k == K_R) begin
      o = '0; o.alu_src_a = 1; o.alu_op = 2'b10;
      push(op, 1'($urandom), 1'($urandom), o, 0, 0);
      o = '0; o.reg_write = 1;
      push(op, 1'($urandom), 1'($urandom), o, 1, 0);
    end else if (k == K_CBZ) begin
      o = '0; o.reg2loc = 1; o.alu_op = 2'b01; o.pc_src = 1; o.pc_write = z;
      push(op, z, 1'($urandom), o, 1, 0);
    end
  endtask

  // Called at posedge+1; drives each cycle, checks at negedge, advances the model.
  task automatic run_n(int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = sched.pop_front();
      Op = c.op; zero = c.zero; mem_ready = c.ready;
      @(negedge clk);
      chk("outputs", 32'(dut_o()), 32'(c.exp));
      chk("retired_count", 32'(retired_count), 32'(exp_ret % 16));
      chk("stall_count", 32'(stall_count), 32'(exp_stall % 16));
      @(posedge clk); #1;
      exp_ret += c.ret_inc;
      exp_stall += c.stall_inc;
    end
  endtask

  task automatic run_all();
    run_n(sched.size());
  endtask

  initial begin
    logic [10:0] rop;
    int k;
    mem_ready = 1'b1; zero = 1'b1; Op = OP_CBZ;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", 32'(dut_o()), 32'd0);
    chk("reset_retired", 32'(retired_count), 32'd0);
    chk("reset_stall", 32'(stall_count), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    add_instr(OP_ADD, 0, 0, 1'b0);
    chk("add_len", 32'(sched.size()), 32'd4);
    run_all();
    chk("add_retired", 32'(retired_count), 32'd1);

    add_instr(OP_LDUR, 0, 3, 1'b0);
    run_all();
    chk("ldur_stall", 32'(stall_count), 32'd3);
    chk("ldur_retired", 32'(retired_count), 32'd2);

    add_instr(OP_CBZ, 0, 0, 1'b1);
    add_instr(11'b101_1010_0101, 0, 0, 1'b0);
    run_all();
    chk("cbz_retired", 32'(retired_count), 32'd4);

    add_instr(11'h000, 0, 0, 1'b0);
    chk("illegal_len", 32'(sched.size()), 32'd2);
    run_all();
    chk("illegal_retired", 32'(retired_count), 32'd4);

    // Abort a store while it waits on memory.
    add_instr(OP_STUR, 0, 4, 1'b0);
    run_n(4);
    Op = OP_STUR; mem_ready = 1'b0;
    #1;
    chk("abort_pre_memwrite", 32'(MemWrite), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_outs", 32'(dut_o()), 32'd0);
    chk("abort_retired", 32'(retired_count), 32'd0);
    chk("abort_stall", 32'(stall_count), 32'd0);
    sched.delete();
    exp_ret = 0; exp_stall = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 15; i++) add_instr(OP_STUR, 0, 0, 1'b0);
    run_all();
    chk("wrap_15", 32'(retired_count), 32'd15);
    add_instr(OP_STUR, 0, 0, 1'b0);
    run_all();
    chk("wrap_0", 32'(retired_count), 32'd0);

    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 4);
      case (k)
        K_LD:  rop = OP_LDUR;
        K_ST:  rop = OP_STUR;
        K_R:   rop = r_ops[$urandom_range(0, 3)];
        K_CBZ: rop = {8'b1011_0100, 3'($urandom)};
        default: begin
          rop = 11'($urandom);
          while (classify(rop) != K_ILL) rop = 11'($urandom);
        end
      endcase
      add_instr(rop, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
      run_all();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got %0d checks expected completion", n_total);
    $fatal(1);
  end
endmodule
